// File: rtl/led_step_sequencer.sv
// LED step sequencer: prescaled tick advances a step index in up/down/bounce modes under KEY control.
// Build option: define LED_SEQ_BOUNCE_EN to compile in bounce mode and its direction register.
module led_step_sequencer #(
  parameter  int N_STEPS  = 4,
  parameter  int TICK_DIV = 67108864,
  localparam int IDX_W    = $clog2(N_STEPS),
  localparam int DIV_W    = $clog2(TICK_DIV)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [3:0]         KEY,
  output logic [IDX_W-1:0]   step_idx,
  output logic [N_STEPS-1:0] step_onehot,
  output logic [1:0]         mode,
  output logic               running,
  output logic               tick
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_t;

  localparam logic [IDX_W-1:0]   IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0]   IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_STEPS - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST_M1 = IDX_W'(N_STEPS - 2);
  localparam logic [DIV_W-1:0]   DIV_ZERO    = DIV_W'(0);
  localparam logic [DIV_W-1:0]   DIV_ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [N_STEPS-1:0] ONEHOT_ONE  = N_STEPS'(1);

  logic [3:0]       r_key_s1, r_key_s2, r_key_prev;
  logic [3:0]       w_key_evt;
  logic [DIV_W-1:0] r_div_cnt, w_div_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  mode_t            r_mode, w_mode_next;
  logic             r_running, w_running_next;
  logic             w_tick, w_adv;
`ifdef LED_SEQ_BOUNCE_EN
  logic             r_dir, w_dir_next;  // 1 = counting up
`endif

  // Two-flop synchroniser plus previous-value flop per key
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_key_s1   <= 4'hF;
      r_key_s2   <= 4'hF;
      r_key_prev <= 4'hF;
    end else begin
      r_key_s1   <= KEY;
      r_key_s2   <= r_key_s1;
      r_key_prev <= r_key_s2;
    end
  end

  // Active-low keys: a press is a 1->0 edge on the synchronised value
  assign w_key_evt = r_key_prev & ~r_key_s2;
  assign w_tick    = (r_div_cnt == DIV_LAST);
  assign w_adv     = (r_running & w_tick) | (~r_running & w_key_evt[2]);

  // Next-state logic: restart beats advance; pause and mode changes apply alongside either
  always_comb begin
    w_idx_next     = r_idx;
    w_mode_next    = r_mode;
    w_running_next = r_running ^ w_key_evt[0];
    w_div_next     = (w_tick) ? DIV_ZERO : (r_div_cnt + DIV_ONE);
`ifdef LED_SEQ_BOUNCE_EN
    w_dir_next     = r_dir;
`endif

    if (w_key_evt[3]) begin
      w_idx_next = IDX_ZERO;
      w_div_next = DIV_ZERO;
`ifdef LED_SEQ_BOUNCE_EN
      w_dir_next = 1'b1;
`endif
    end else if (w_adv) begin
      case (r_mode)
        MODE_UP:   w_idx_next = (r_idx == IDX_LAST) ? IDX_ZERO : (r_idx + IDX_ONE);
        MODE_DOWN: w_idx_next = (r_idx == IDX_ZERO) ? IDX_LAST : (r_idx - IDX_ONE);
`ifdef LED_SEQ_BOUNCE_EN
        MODE_BOUNCE: begin
          if (r_dir) begin
            if (r_idx == IDX_LAST) begin
              w_idx_next = IDX_LAST_M1;
              w_dir_next = 1'b0;
            end else begin
              w_idx_next = r_idx + IDX_ONE;
            end
          end else begin
            if (r_idx == IDX_ZERO) begin
              w_idx_next = IDX_ONE;
              w_dir_next = 1'b1;
            end else begin
              w_idx_next = r_idx - IDX_ONE;
            end
          end
        end
`endif
        default:   w_idx_next = r_idx;
      endcase
    end else begin
      w_idx_next = r_idx;
    end

    // Mode change uses the old mode for any same-cycle advance above
    if (w_key_evt[1]) begin
      case (r_mode)
        MODE_UP:     w_mode_next = MODE_DOWN;
`ifdef LED_SEQ_BOUNCE_EN
        MODE_DOWN:   w_mode_next = MODE_BOUNCE;
`else
        MODE_DOWN:   w_mode_next = MODE_UP;
`endif
        MODE_BOUNCE: w_mode_next = MODE_UP;
        default:     w_mode_next = MODE_UP;
      endcase
`ifdef LED_SEQ_BOUNCE_EN
      w_dir_next = 1'b1;
`endif
    end else begin
      w_mode_next = r_mode;
    end
  end

  // State registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_div_cnt <= DIV_ZERO;
      r_idx     <= IDX_ZERO;
      r_mode    <= MODE_UP;
      r_running <= 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
      r_dir     <= 1'b1;
`endif
    end else begin
      r_div_cnt <= w_div_next;
      r_idx     <= w_idx_next;
      r_mode    <= w_mode_next;
      r_running <= w_running_next;
`ifdef LED_SEQ_BOUNCE_EN
      r_dir     <= w_dir_next;
`endif
    end
  end

  assign step_idx    = r_idx;
  assign step_onehot = ONEHOT_ONE << r_idx;
  assign mode        = r_mode;
  assign running     = r_running;
  assign tick        = w_tick;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Self-checking bench for led_step_sequencer (N_STEPS=5, TICK_DIV=4) against a behavioural model.
module tb_led_step_sequencer;
  localparam int N  = 5;
  localparam int TD = 4;
`ifdef LED_SEQ_BOUNCE_EN
  localparam int NMODES = 3;
`else
  localparam int NMODES = 2;
`endif
  localparam logic [11:0] RESET_VEC = {3'd0, 5'b00001, 2'd0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key = 4'hF;
  logic [2:0] step_idx;
  logic [4:0] step_onehot;
  logic [1:0] mode;
  logic       running;
  logic       tick;
  wire  [11:0] act = {step_idx, step_onehot, mode, running, tick};

  int checks = 0;
  int errors = 0;

  // Behavioural model: index, mode, run flag, bounce phase on a 0..2(N-1)-1 ring, edge count
  int         m_idx = 0, m_mode = 0, m_phase = 0, m_n = 0;
  bit         m_run = 1'b1;
  logic [3:0] kh [3];

  led_step_sequencer #(.N_STEPS(N), .TICK_DIV(TD)) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(key), .step_idx(step_idx),
    .step_onehot(step_onehot), .mode(mode), .running(running), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int fold(input int p);
    return (p < N) ? p : 2 * (N - 1) - p;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [4:0] oh;
    oh = 5'd1 << m_idx;
    return {3'(m_idx), oh, 2'(m_mode), m_run, 1'((m_n % TD) == TD - 1)};
  endfunction

  task automatic model_update(input logic [3:0] k, input logic r);
    logic [3:0] ev;
    bit t, adv;
    if (r) begin
      m_idx = 0; m_mode = 0; m_run = 1'b1; m_phase = 0; m_n = 0;
      kh[0] = 4'hF; kh[1] = 4'hF; kh[2] = 4'hF;
    end else begin
      t   = ((m_n % TD) == TD - 1);
      ev  = kh[2] & ~kh[1];
      adv = (m_run && t) || (!m_run && ev[2]);
      if (ev[3]) begin
        m_idx = 0; m_phase = 0; m_n = 0;
      end else begin
        m_n = m_n + 1;
        if (adv) begin
          if (m_mode == 0) m_idx = (m_idx + 1) % N;
          else if (m_mode == 1) m_idx = (m_idx + N - 1) % N;
          else begin
            m_phase = (m_phase + 1) % (2 * (N - 1));
            m_idx   = fold(m_phase);
          end
        end
      end
      if (ev[1]) begin
        m_mode  = (m_mode + 1) % NMODES;
        m_phase = m_idx;
      end
      if (ev[0]) m_run = !m_run;
      kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = k;
    end
  endtask

  task automatic step(input logic [3:0] k, input logic r);
    @(negedge clk);
    key = k; reset = r;
    @(posedge clk);
    model_update(k, r);
    #1;
  endtask

  task automatic test_reset();
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    checks++;
    if (act !== RESET_VEC) begin
      errors++; $display("FAIL reset: got %b expected %b", act, RESET_VEC);
    end
  endtask

  task automatic test_up();
    int ticks = 0;
    for (int i = 0; i < 24; i++) begin
      step(4'hF, 1'b0);
      ticks += int'(tick);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL up cycle %0d: got %b expected %b", i, act, exp_vec());
      end
    end
    checks++;
    if (ticks != 6) begin
      errors++; $display("FAIL tick_period: got %0d ticks expected 6", ticks);
    end
  endtask

  task automatic test_mode_down();
    for (int i = 0; i < 26; i++) begin
      step((i < 3) ? 4'b1101 : 4'hF, 1'b0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL down cycle %0d: got %b expected %b", i, act, exp_vec());
      end
    end
    checks++;
    if (mode !== 2'd1) begin
      errors++; $display("FAIL down_mode: got %0d expected 1", mode);
    end
  endtask

  task automatic test_bounce();
    logic [1:0] want;
`ifdef LED_SEQ_BOUNCE_EN
    want = 2'd2;
`else
    want = 2'd0;
`endif
    for (int i = 0; i < 50; i++) begin
      step((i < 3) ? 4'b1101 : 4'hF, 1'b0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL bounce cycle %0d: got %b expected %b", i, act, exp_vec());
      end
    end
    checks++;
    if (mode !== want) begin
      errors++; $display("FAIL bounce_mode: got %0d expected %0d", mode, want);
    end
  endtask

  task automatic test_pause();
    logic [2:0] held;
    for (int i = 0; i < 8; i++) begin
      step((i < 3) ? 4'b1110 : 4'hF, 1'b0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL pause cycle %0d: got %b expected %b", i, act, exp_vec());
      end
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL pause_running: got %b expected 0", running);
    end
    held = step_idx;
    for (int i = 0; i < 40; i++) begin
      step(4'hF, 1'b0);
      checks++;
      if (step_idx !== held) begin
        errors++; $display("FAIL pause_hold cycle %0d: got %0d expected %0d", i, step_idx, held);
      end
    end
    for (int p = 0; p < 2; p++) begin
      held = step_idx;
      for (int e = 0; e < 6; e++) begin
        step((e < 2) ? 4'b1011 : 4'hF, 1'b0);
        checks++;
        if (e < 2 && step_idx !== held) begin
          errors++; $display("FAIL single_step_early press %0d edge %0d: got %0d expected %0d", p, e, step_idx, held);
        end else if (e == 2 && (step_idx === held || act !== exp_vec())) begin
          errors++; $display("FAIL single_step press %0d: got %b expected %b", p, act, exp_vec());
        end else if (e > 2 && act !== exp_vec()) begin
          errors++; $display("FAIL single_step_after press %0d: got %b expected %b", p, act, exp_vec());
        end
      end
    end
  endtask

  task automatic test_restart();
    bit found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step((i < 3) ? 4'b1110 : 4'hF, 1'b0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL resume cycle %0d: got %b expected %b", i, act, exp_vec());
      end
    end
    for (int i = 0; i < 200 && !found; i++) begin
      step(4'hF, 1'b0);
      found = (m_n % TD == 1) && (m_idx == 3);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL restart_setup: got no idx 3 slot expected one within 200 cycles");
    end
    for (int e = 0; e < 3; e++) step(4'b0111, 1'b0);
    checks++;
    if (act !== exp_vec() || step_idx !== 3'd0 || tick !== 1'b0) begin
      errors++; $display("FAIL restart: got %b expected %b", act, exp_vec());
    end
    for (int j = 1; j <= 4; j++) begin
      step(4'hF, 1'b0);
      checks++;
      if (tick !== 1'(j == 3) || act !== exp_vec()) begin
        errors++; $display("FAIL restart_tick %0d: got %b expected %b", j, act, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    checks++;
    if (act !== RESET_VEC) begin
      errors++; $display("FAIL reset_mid: got %b expected %b", act, RESET_VEC);
    end
  endtask

  task automatic test_mode_cycle();
    int want [3];
`ifdef LED_SEQ_BOUNCE_EN
    want = '{1, 2, 0};
`else
    want = '{1, 0, 1};
`endif
    step(4'hF, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) step((i < 2) ? 4'b1101 : 4'hF, 1'b0);
      checks++;
      if (mode !== 2'(want[p]) || act !== exp_vec()) begin
        errors++; $display("FAIL mode_cycle press %0d: got mode %0d expected %0d", p, mode, want[p]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] kr = 4'hF;
    logic       rr;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) kr = kr ^ (4'b0001 << $urandom_range(0, 3));
      rr = ($urandom_range(0, 149) == 0);
      step(kr, rr);
      checks++;
      if (act !== exp_vec() || mode === 2'd3) begin
        errors++; $display("FAIL random cycle %0d: got %b expected %b", i, act, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_mode_down();
    test_bounce();
    test_pause();
    test_restart();
    test_reset_mid();
    test_mode_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
